// File: rtl/wave_meas_pkg.sv
// Shared types and constants for the wave_meas period/high-time meter.
package wave_meas_pkg;

    localparam int DUTY_W    = 8;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } wave_state_e;

endpackage

// File: rtl/wave_meas_div.sv
// Restoring divider producing floor(high*2^DUTY_W/period) one quotient bit per cycle.
// Relies on high < period, so the partial remainder always fits in CNT_W bits.
module wave_meas_div
    import wave_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [CNT_W-1:0]  high,
    input  logic [CNT_W-1:0]  period,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quot
);
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  dvs_q, dvs_d;
    logic [DUTY_W-1:0] quot_q, quot_d;
    logic [3:0]        iter_q, iter_d;
    logic              run_q, run_d;
    logic              done_q, done_d;
    logic [CNT_W:0]    rem_x2;
    logic [CNT_W:0]    rem_diff;

    always_comb begin
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quot_d   = quot_q;
        iter_d   = iter_q;
        run_d    = run_q;
        done_d   = 1'b0;
        rem_x2   = {rem_q, 1'b0};
        rem_diff = rem_x2 - {1'b0, dvs_q};
        if (start) begin
            rem_d  = high;
            dvs_d  = period;
            quot_d = '0;
            iter_d = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (rem_x2 >= {1'b0, dvs_q}) begin
                rem_d  = rem_diff[CNT_W-1:0];
                quot_d = {quot_q[DUTY_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_x2[CNT_W-1:0];
                quot_d = {quot_q[DUTY_W-2:0], 1'b0};
            end
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'(DUTY_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quot_q <= quot_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    // Busy also covers the done cycle so the owner can consume quot before a restart.
    assign busy = run_q | done_q;
    assign done = done_q;
    assign quot = quot_q;

endmodule

// File: rtl/wave_meas.sv
// wave_meas: continuous period / high-time meter for an asynchronous input.
// Define WAVE_MEAS_DUTY_CODE_EN to add the duty_code divider (adds 9 cycles latency).
module wave_meas
    import wave_meas_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = 32'hFFFF_FFFF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              sig_in,
    input  logic              enable,
    input  logic              meas_ack,
    output logic [CNT_W-1:0]  meas_period,
    output logic [CNT_W-1:0]  meas_high,
    output logic [DUTY_W-1:0] duty_code,
    output logic              meas_valid,
    output logic              overrun,
    output logic              timeout,
    output wave_state_e       state_dbg
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic        sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic        rise, fall;
    wave_state_e state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic        cmpl, to_hit;
    logic        timeout_q, timeout_d;
    logic        cap_vld_q, cap_vld_d;
    logic [CNT_W-1:0] cap_period_q, cap_period_d, cap_high_q, cap_high_d;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        rise    = sync2_q & ~sync3_q;
        fall    = ~sync2_q & sync3_q;
    end

    // A completing rise latches the running counts and reloads to 1, so no period is lost.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        cmpl     = 1'b0;
        to_hit   = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            period_d = '0;
            high_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        state_d  = ST_HIGH;
                        period_d = ONE;
                        high_d   = ONE;
                    end
                end
                ST_HIGH: begin
                    if (period_q >= TIMEOUT_C) begin
                        to_hit   = 1'b1;
                        state_d  = ST_ARM;
                        period_d = '0;
                        high_d   = '0;
                    end else if (fall) begin
                        state_d  = ST_LOW;
                        period_d = period_q + ONE;
                    end else begin
                        period_d = period_q + ONE;
                        high_d   = high_q + ONE;
                    end
                end
                ST_LOW: begin
                    if (period_q >= TIMEOUT_C) begin
                        to_hit   = 1'b1;
                        state_d  = ST_ARM;
                        period_d = '0;
                        high_d   = '0;
                    end else if (rise) begin
                        cmpl     = 1'b1;
                        state_d  = ST_HIGH;
                        period_d = ONE;
                        high_d   = ONE;
                    end else begin
                        period_d = period_q + ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        timeout_d    = to_hit;
        cap_vld_d    = cmpl;
        cap_period_d = cmpl ? period_q : cap_period_q;
        cap_high_d   = cmpl ? high_q : cap_high_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            state_q      <= ST_IDLE;
            period_q     <= '0;
            high_q       <= '0;
            timeout_q    <= 1'b0;
            cap_vld_q    <= 1'b0;
            cap_period_q <= '0;
            cap_high_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            state_q      <= state_d;
            period_q     <= period_d;
            high_q       <= high_d;
            timeout_q    <= timeout_d;
            cap_vld_q    <= cap_vld_d;
            cap_period_q <= cap_period_d;
            cap_high_q   <= cap_high_d;
        end
    end

    logic             latch, drop;
    logic [CNT_W-1:0] new_period, new_high;

`ifdef WAVE_MEAS_DUTY_CODE_EN
    logic              div_busy, div_done, div_start;
    logic [DUTY_W-1:0] div_quot;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  hold_period_q, hold_period_d, hold_high_q, hold_high_d;

    // Completions arriving while the divider is still working are discarded.
    always_comb begin
        div_start     = cap_vld_q & ~div_busy;
        drop          = cap_vld_q & div_busy;
        latch         = div_done;
        hold_period_d = div_start ? cap_period_q : hold_period_q;
        hold_high_d   = div_start ? cap_high_q : hold_high_q;
        new_period    = hold_period_q;
        new_high      = hold_high_q;
        duty_d        = div_done ? div_quot : duty_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hold_period_q <= '0;
            hold_high_q   <= '0;
            duty_q        <= '0;
        end else begin
            hold_period_q <= hold_period_d;
            hold_high_q   <= hold_high_d;
            duty_q        <= duty_d;
        end
    end

    wave_meas_div #(.CNT_W(CNT_W)) u_div (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (div_start),
        .high   (cap_high_q),
        .period (cap_period_q),
        .busy   (div_busy),
        .done   (div_done),
        .quot   (div_quot)
    );

    assign duty_code = duty_q;
`else
    always_comb begin
        latch      = cap_vld_q;
        drop       = 1'b0;
        new_period = cap_period_q;
        new_high   = cap_high_q;
    end

    assign duty_code = '0;
`endif

    // meas_valid/meas_ack: a result stays valid until a cycle with meas_ack=1; a new
    // result latching in that same cycle keeps it valid. Unacked overwrite sets overrun.
    logic             meas_valid_q, meas_valid_d, overrun_q, overrun_d;
    logic [CNT_W-1:0] meas_period_q, meas_period_d, meas_high_q, meas_high_d;

    always_comb begin
        meas_period_d = latch ? new_period : meas_period_q;
        meas_high_d   = latch ? new_high : meas_high_q;
        meas_valid_d  = (meas_valid_q & ~meas_ack) | latch;
        overrun_d     = meas_ack ? 1'b0 : (overrun_q | (latch & meas_valid_q) | drop);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            meas_valid_q  <= meas_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign meas_period = meas_period_q;
    assign meas_high   = meas_high_q;
    assign meas_valid  = meas_valid_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_wave_meas.sv
// Bench for wave_meas: waveform driver, edge-timing reference model and result scoreboard.
module tb_wave_meas;
    import wave_meas_pkg::*;

    localparam int W = 32;
`ifdef WAVE_MEAS_DUTY_CODE_EN
    localparam int LAT = 13;
`else
    localparam int LAT = 4;
`endif

    // clock / reset
    logic CLK = 1'b0;
    logic RESET, sig_in, enable, meas_ack;
    always #5 CLK = ~CLK;

    logic [W-1:0] meas_period, meas_high, to_period, to_high;
    logic [7:0]   duty_code, to_duty;
    logic         meas_valid, overrun, timeout, to_valid, to_overrun, to_timeout;
    wave_state_e  state_dbg, to_state;

    wave_meas #(.CNT_W(W), .TIMEOUT(400)) u_dut (
        .CLK(CLK), .RESET(RESET), .sig_in(sig_in), .enable(enable), .meas_ack(meas_ack),
        .meas_period(meas_period), .meas_high(meas_high), .duty_code(duty_code),
        .meas_valid(meas_valid), .overrun(overrun), .timeout(timeout), .state_dbg(state_dbg)
    );

    wave_meas #(.CNT_W(W), .TIMEOUT(100)) u_to (
        .CLK(CLK), .RESET(RESET), .sig_in(sig_in), .enable(enable), .meas_ack(meas_ack),
        .meas_period(to_period), .meas_high(to_high), .duty_code(to_duty),
        .meas_valid(to_valid), .overrun(to_overrun), .timeout(to_timeout), .state_dbg(to_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: results derived from the cycles at which the bench drove edges
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_h_q[$];
    int           exp_t_q[$];
    int  cyc = 0;
    int  last_rise = 0;
    int  last_fall = 0;
    bit  mdl_on = 0;
    bit  mdl_started = 0;
    bit  auto_ack = 0;
    bit  to_watch = 0;
    int  to_cnt = 0;
    int  to_cyc = 0;
    logic sig_prev = 1'b0;

    function automatic logic [7:0] exp_duty(input int h, input int p);
`ifdef WAVE_MEAS_DUTY_CODE_EN
        return 8'((h * 256) / p);
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_reset();
        mdl_on = 1;
        mdl_started = 0;
    endtask

    task automatic monitor();
        logic [W-1:0] p, h;
        int t;
        if (auto_ack) begin
            if (meas_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", meas_valid, 0);
                end else begin
                    p = exp_q.pop_front();
                    h = exp_h_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("period", meas_period, p);
                    check("high", meas_high, h);
                    check("duty", duty_code, exp_duty(int'(h), int'(p)));
                    check("latency", cyc - t, LAT);
                    check("overrun_acked", overrun, 0);
                end
                meas_ack = 1'b1;
            end else begin
                meas_ack = 1'b0;
            end
        end
        if (to_watch && to_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    endtask

    // driver: one clock cycle with sig_in held at s
    task automatic tick(input logic s);
        if (s && !sig_prev && mdl_on) begin
            if (mdl_started) begin
                exp_q.push_back(W'(cyc - last_rise));
                exp_h_q.push_back(W'(last_fall - last_rise));
                exp_t_q.push_back(cyc);
            end
            mdl_started = 1;
            last_rise = cyc;
        end
        if (!s && sig_prev) last_fall = cyc;
        sig_prev = s;
        sig_in = s;
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic pulse(input int h, input int l);
        for (int i = 0; i < h; i++) tick(1'b1);
        for (int i = 0; i < l; i++) tick(1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < LAT + 4; i++) tick(sig_prev);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic rearm();
        enable = 1'b0;
        tick(1'b0);
        tick(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        model_reset();
    endtask

    initial begin
        int h, l, t_hold;
        RESET = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        meas_ack = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check("rst_period", meas_period, 0);
        check("rst_high", meas_high, 0);
        check("rst_duty", duty_code, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", state_dbg, ST_IDLE);

        RESET = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("arm_state", state_dbg, ST_ARM);
        check("arm_valid", meas_valid, 0);
        model_reset();
        auto_ack = 1;

        for (int i = 0; i < 4; i++) pulse(3, 5);
        drain("q_3_5");
        for (int i = 0; i < 5; i++) pulse(4, 4);
        drain("q_4_4");
        for (int i = 0; i < 3; i++) pulse(1, 255);
        drain("q_1_255");
        for (int i = 0; i < 12; i++) begin
            h = $urandom_range(15, 1);
            l = $urandom_range(15, (h >= 9) ? 1 : 10 - h);
            pulse(h, l);
        end
        drain("q_random");

        // no ack across two results
        rearm();
        mdl_on = 0;
        auto_ack = 0;
        meas_ack = 1'b0;
        pulse(10, 10);
        pulse(12, 8);
        pulse(5, 5);
        for (int i = 0; i < LAT + 2; i++) tick(1'b0);
        check("ovr_valid", meas_valid, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_period", meas_period, 20);
        check("ovr_high", meas_high, 12);
        meas_ack = 1'b1;
        tick(1'b0);
        meas_ack = 1'b0;
        check("ack_valid", meas_valid, 0);
        check("ack_overrun", overrun, 0);

        // enable dropped mid-period
        rearm();
        auto_ack = 1;
        pulse(6, 6);
        pulse(6, 6);
        for (int i = 0; i < 3; i++) tick(1'b1);
        enable = 1'b0;
        mdl_on = 0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) pulse(7, 5);
        drain("q_enable");

        // reset during LOW
        pulse(8, 0);
        for (int i = 0; i < 6; i++) tick(1'b0);
        check("low_state", state_dbg, ST_LOW);
        RESET = 1'b0;
        mdl_on = 0;
        #2;
        check("mid_rst_period", meas_period, 0);
        check("mid_rst_high", meas_high, 0);
        check("mid_rst_valid", meas_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", state_dbg, ST_IDLE);
        tick(1'b0);
        tick(1'b0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) pulse(5, 9);
        drain("q_reset");

        // sig_in held high on the TIMEOUT=100 instance
        RESET = 1'b0;
        mdl_on = 0;
        tick(1'b0);
        tick(1'b0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        model_reset();
        pulse(6, 6);
        pulse(6, 6);
        to_watch = 1;
        to_cnt = 0;
        t_hold = cyc;
        for (int i = 0; i < 150; i++) tick(1'b1);
        to_watch = 0;
        check("to_pulses", to_cnt, 1);
        check("to_delay", to_cyc - t_hold, 103);
        check("to_state", to_state, ST_ARM);
        check("to_period", to_period, 12);
        check("to_high", to_high, 6);
        check("main_no_to", timeout, 0);
        tick(1'b0);
        drain("q_timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
